// File: rtl/pipe_mul4_if.sv
// Operand/product bus for the pipelined 4x4 multiplier.
interface pipe_mul4_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0]   mul_a;
  logic [WIDTH-1:0]   mul_b;
  logic [2*WIDTH-1:0] mul_out;

  modport master (output mul_a, output mul_b, input mul_out);
  modport slave  (input mul_a, input mul_b, output mul_out);
endinterface

// File: rtl/pipe_mul4_top.sv
// Fully pipelined unsigned WIDTHxWIDTH shift-and-add multiplier.
// Four register stages: operands, partial products, pair sums, product.
// rst_n is active-high despite its name and clears every stage asynchronously.

// One partial-product row: operand a shifted by the row index, gated by one bit of b.
module pipe_mul4_pp_lane #(
  parameter int WIDTH = 4,
  parameter int IDX   = 0
) (
  input  logic [WIDTH-1:0]   a,
  input  logic               b_bit,
  output logic [2*WIDTH-1:0] pp
);
  localparam int PW = 2 * WIDTH;

  // Row is zero when the multiplier bit is clear.
  always_comb begin
    pp = '0;
    if (b_bit) pp = PW'(a) << IDX;
  end
endmodule

module pipe_mul4_top #(
  parameter int WIDTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  pipe_mul4_if.slave bus
);
  localparam int PW = 2 * WIDTH;

  logic [WIDTH-1:0]           a_r, b_r;
  logic [WIDTH-1:0][PW-1:0]   pp_c, pp_r;
  logic [PW-1:0]              s01, s23;
  logic [PW-1:0]              prod_r;

  // S0: capture operands.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      a_r <= '0;
      b_r <= '0;
    end else begin
      a_r <= bus.mul_a;
      b_r <= bus.mul_b;
    end
  end

  // One partial-product generator per multiplier bit.
  for (genvar i = 0; i < WIDTH; i++) begin : g_pp
    pipe_mul4_pp_lane #(.WIDTH(WIDTH), .IDX(i)) u_lane (
      .a     (a_r),
      .b_bit (b_r[i]),
      .pp    (pp_c[i])
    );
  end

  // S1: register all partial-product rows.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) pp_r <= '0;
    else       pp_r <= pp_c;
  end

  // S2: first adder-tree level; max pair sum fits in PW bits.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      s01 <= '0;
      s23 <= '0;
    end else begin
      s01 <= pp_r[0] + pp_r[1];
      s23 <= pp_r[2] + pp_r[3];
    end
  end

  // S3: final sum; 15*15=225 never overflows 8 bits.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) prod_r <= '0;
    else       prod_r <= s01 + s23;
  end

  assign bus.mul_out = prod_r;
endmodule

// File: tb/tb_pipe_mul4_top.sv
// Scoreboard bench for pipe_mul4_top: stimulus pushes expected products,
// a negedge monitor pops them once the bench's own 4-deep issue tracker says
// a result is due; any other cycle must show 0.
module tb_pipe_mul4_top;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic issue = 1'b0;
  logic [3:0] vld;
  int total = 0;
  int bad = 0;
  int exp_q[$];

  pipe_mul4_if #(.WIDTH(4)) bus ();

  pipe_mul4_top #(.WIDTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Bench-side latency tracker: a pair issued before edge N is due after edge N+3.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) vld <= '0;
    else       vld <= {vld[2:0], issue};
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one operand pair for the next rising edge and record its product.
  task automatic drive(input int a, input int b);
    @(posedge clk);
    #1;
    bus.mul_a = 4'(a);
    bus.mul_b = 4'(b);
    exp_q.push_back(a * b);
    issue = 1'b1;
  endtask

  // Assert reset just after an edge, flushing the model of in-flight products.
  task automatic enter_reset(input int a, input int b);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    issue = 1'b0;
    exp_q.delete();
    bus.mul_a = 4'(a);
    bus.mul_b = 4'(b);
  endtask

  task automatic leave_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    bus.mul_a = '0;
    bus.mul_b = '0;
  endtask

  // Monitor: compare every cycle away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      check("reset_zero", int'(bus.mul_out), 0);
    end else if (vld[3]) begin
      if (exp_q.size() == 0) check("q_underflow", int'(bus.mul_out), -1);
      else check("product", int'(bus.mul_out), exp_q.pop_front());
    end else begin
      check("drain_zero", int'(bus.mul_out), 0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.mul_a = 4'd7;
    bus.mul_b = 4'd9;
    // Reset held for 5 cycles with nonzero operands.
    repeat (5) @(posedge clk);
    leave_reset();
    repeat (2) @(posedge clk);

    // Single-shot latency, zeros around it.
    drive(1, 9);
    repeat (5) drive(0, 0);

    // Streaming products 9,16,21,24,25,24,21,16,9.
    for (int i = 1; i <= 9; i++) drive(i, 10 - i);

    // Extremes.
    drive(15, 15); drive(15, 0); drive(0, 15); drive(15, 1); drive(8, 8);
    repeat (4) drive(15, 15);

    // Asynchronous reset mid-cycle while mul_out is 225.
    @(posedge clk);
    #2;
    check("pre_async", int'(bus.mul_out), 225);
    rst_n = 1'b1;
    issue = 1'b0;
    exp_q.delete();
    #1;
    check("async_rst", int'(bus.mul_out), 0);
    leave_reset();

    // Mid-stream reset: (3,5),(4,5) in flight, (5,5) applied during reset.
    drive(3, 5);
    drive(4, 5);
    enter_reset(5, 5);
    leave_reset();
    repeat (6) drive(0, 0);

    // Exhaustive back-to-back.
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        drive(a, b);
    repeat (5) drive(0, 0);
    @(posedge clk);
    #1;
    issue = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("q_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
